// File: rtl/nonce_dispatcher.sv
// Nonce dispatcher: splits each job's nonce space across NUM_ENG miners, launches them one per cycle,
// relaunches engines that miss and latches the first winning nonce.
module nonce_dispatcher #(
  parameter int unsigned NUM_ENG     = 4,
  parameter int unsigned NONCE_W     = 192,
  parameter int unsigned STRIDE_LOG2 = 32,
  localparam int unsigned IDX_W      = $clog2(NUM_ENG)
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Start_I,
  input  logic                       Abort_I,
  input  logic [NONCE_W-1:0]         BaseNonce_I,
  output logic [NUM_ENG-1:0]         EngStrt_O,
  output logic [NUM_ENG-1:0]         EngClear_O,
  output logic [NUM_ENG*NONCE_W-1:0] EngNonce_O,
  input  logic [NUM_ENG-1:0]         EngRdy_I,
  input  logic [NUM_ENG-1:0]         EngVld_I,
  input  logic [NUM_ENG*NONCE_W-1:0] EngNonce_I,
  output logic                       Busy_O,
  output logic                       Found_O,
  output logic [IDX_W-1:0]           FoundEng_O,
  output logic [NONCE_W-1:0]         FoundNonce_O,
  output logic                       Irq_O,
  output logic [31:0]                BatchCount_O
);

  localparam int unsigned CNT_W   = $clog2(NUM_ENG + 1);
  localparam int unsigned BATCH_W = 32;
  localparam int unsigned BSUM_W  = BATCH_W + 1;
  localparam logic [NONCE_W-1:0] RELAUNCH_STEP = NONCE_W'(NUM_ENG) << STRIDE_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state, w_state_next;
  logic                 r_busy;
  logic [NONCE_W-1:0]   r_nonce [NUM_ENG];
  logic [NUM_ENG-1:0]   r_pending, r_eng_strt, r_eng_clear;
  logic [IDX_W-1:0]     r_rr_ptr, r_found_eng;
  logic                 r_found, r_irq;
  logic [NONCE_W-1:0]   r_found_nonce;
  logic [BATCH_W-1:0]   r_batch;

  logic                 w_in_run, w_do_start, w_do_abort;
  logic [NUM_ENG-1:0]   w_rdy, w_hit, w_miss, w_pend_upd, w_gnt_mask;
  logic [CNT_W-1:0]     w_rdy_cnt;
  logic [IDX_W-1:0]     w_win_idx, w_rr_base, w_scan, w_gnt_idx, w_rr_next;
  logic [NONCE_W-1:0]   w_win_nonce;
  logic [BSUM_W-1:0]    w_batch_sum;
  logic [BATCH_W-1:0]   w_batch_next;
  logic                 w_gnt_vld;

  assign w_in_run   = (r_state == S_RUN);
  assign w_do_abort = Abort_I;
  assign w_do_start = Start_I && !Abort_I && (r_state != S_RUN);

  always_ff @(posedge Clk) begin : fsm_state
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == S_RUN);
    end
  end

  always_comb begin : fsm_next
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_do_start) w_state_next = S_RUN;
      S_RUN:          if (|w_hit) w_state_next = S_DONE;
      default:        w_state_next = S_IDLE;
    endcase
    if (w_do_abort) w_state_next = S_IDLE;
  end

  // Ready coinciding with that engine's own launch strobe is a protocol error and dropped.
  always_comb begin : engine_decode
    w_rdy       = w_in_run ? (EngRdy_I & ~r_eng_strt) : '0;
    w_hit       = w_rdy & EngVld_I;
    w_miss      = w_rdy & ~EngVld_I;
    w_rdy_cnt   = '0;
    w_win_idx   = '0;
    w_win_nonce = '0;
    for (int i = int'(NUM_ENG) - 1; i >= 0; i--) begin
      w_rdy_cnt = w_rdy_cnt + CNT_W'(w_rdy[i]);
      if (w_hit[i]) begin
        w_win_idx   = IDX_W'(i);
        w_win_nonce = EngNonce_I[i*NONCE_W +: NONCE_W];
      end
    end
    w_batch_sum  = {1'b0, r_batch} + BSUM_W'(w_rdy_cnt);
    w_batch_next = w_batch_sum[BATCH_W] ? '1 : w_batch_sum[BATCH_W-1:0];
    w_pend_upd   = w_do_start ? '1 : (r_pending | w_miss);
    w_rr_base    = w_do_start ? '0 : r_rr_ptr;
  end

  // Grant is taken from the updated pending mask so a launch strobe follows its trigger by one cycle.
  always_comb begin : rr_grant
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      w_scan = IDX_W'((32'(w_rr_base) + i) % NUM_ENG);
      if (!w_gnt_vld && w_pend_upd[w_scan]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
    w_gnt_mask = w_gnt_vld ? (NUM_ENG'(1) << w_gnt_idx) : '0;
    w_rr_next  = IDX_W'((32'(w_gnt_idx) + 1) % NUM_ENG);
  end

  always_ff @(posedge Clk) begin : datapath
    if (!Rst_n) begin
      for (int unsigned k = 0; k < NUM_ENG; k++) r_nonce[k] <= '0;
      r_pending     <= '0;
      r_eng_strt    <= '0;
      r_eng_clear   <= '0;
      r_rr_ptr      <= '0;
      r_found       <= 1'b0;
      r_irq         <= 1'b0;
      r_found_eng   <= '0;
      r_found_nonce <= '0;
      r_batch       <= '0;
    end else begin
      r_eng_strt  <= '0;
      r_eng_clear <= '0;
      if (w_do_abort) begin
        r_eng_clear   <= '1;
        r_pending     <= '0;
        r_found       <= 1'b0;
        r_irq         <= 1'b0;
        r_found_nonce <= '0;
      end else if (w_do_start) begin
        for (int unsigned k = 0; k < NUM_ENG; k++)
          r_nonce[k] <= BaseNonce_I + (NONCE_W'(k) << STRIDE_LOG2);
        r_eng_clear   <= '1;
        r_batch       <= '0;
        r_found       <= 1'b0;
        r_irq         <= 1'b0;
        r_found_eng   <= '0;
        r_found_nonce <= '0;
        r_pending     <= w_pend_upd & ~w_gnt_mask;
        r_eng_strt    <= w_gnt_mask;
        r_rr_ptr      <= w_rr_next;
      end else if (w_in_run) begin
        r_batch <= w_batch_next;
        for (int unsigned k = 0; k < NUM_ENG; k++)
          if (w_miss[k]) r_nonce[k] <= r_nonce[k] + RELAUNCH_STEP;
        if (|w_hit) begin
          r_found       <= 1'b1;
          r_irq         <= 1'b1;
          r_found_eng   <= w_win_idx;
          r_found_nonce <= w_win_nonce;
          r_pending     <= '0;
          r_eng_clear   <= '1;
        end else begin
          r_pending  <= w_pend_upd & ~w_gnt_mask;
          r_eng_strt <= w_gnt_mask;
          if (w_gnt_vld) r_rr_ptr <= w_rr_next;
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_ENG); g++) begin : g_nonce_out
    assign EngNonce_O[g*NONCE_W +: NONCE_W] = r_nonce[g];
  end

  assign EngStrt_O    = r_eng_strt;
  assign EngClear_O   = r_eng_clear;
  assign Busy_O       = r_busy;
  assign Found_O      = r_found;
  assign FoundEng_O   = r_found_eng;
  assign FoundNonce_O = r_found_nonce;
  assign Irq_O        = r_irq;
  assign BatchCount_O = r_batch;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Self-checking bench for nonce_dispatcher: scenario tasks checked against an event-level model
// of per-engine nonces, round-robin launch order and batch count.
module tb_nonce_dispatcher;

  localparam int NE = 4;
  localparam int NW = 192;
  localparam int SL = 32;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n, start, abort;
  logic [NW-1:0]     base;
  logic [NE-1:0]     eng_strt, eng_clear, eng_rdy, eng_vld;
  logic [NE*NW-1:0]  eng_nonce_o, eng_nonce_i;
  logic              busy, found, irq;
  logic [IW-1:0]     found_eng;
  logic [NW-1:0]     found_nonce;
  logic [31:0]       batch;

  int checks = 0;
  int errors = 0;

  // Model: expected start nonce per engine, next round-robin start slot, batch count.
  logic [NW-1:0] m_nonce [NE];
  int            m_rr;
  int            m_batch;

  nonce_dispatcher #(.NUM_ENG(NE), .NONCE_W(NW), .STRIDE_LOG2(SL)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start_I(start), .Abort_I(abort), .BaseNonce_I(base),
    .EngStrt_O(eng_strt), .EngClear_O(eng_clear), .EngNonce_O(eng_nonce_o),
    .EngRdy_I(eng_rdy), .EngVld_I(eng_vld), .EngNonce_I(eng_nonce_i),
    .Busy_O(busy), .Found_O(found), .FoundEng_O(found_eng), .FoundNonce_O(found_nonce),
    .Irq_O(irq), .BatchCount_O(batch)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NW-1:0] rand_nonce();
    logic [NW-1:0] v;
    for (int i = 0; i < NW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [NW-1:0] onv(input int k);
    return eng_nonce_o[k*NW +: NW];
  endfunction

  task automatic test_reset(input bit mid);
    if (mid) do_misses(NE'($urandom_range(1, (1 << NE) - 1)));
    rst_n = 1'b0; eng_rdy = NE'($urandom); eng_vld = NE'($urandom);
    step();
    eng_rdy = '0; eng_vld = '0;
    checks++; if (eng_strt !== '0 || eng_clear !== '0) begin errors++; $display("FAIL reset_strb: strt %b clear %b want 0", eng_strt, eng_clear); end
    checks++; if (eng_nonce_o !== '0) begin errors++; $display("FAIL reset_nonce: got %h want 0", eng_nonce_o); end
    checks++; if (busy !== 1'b0 || found !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL reset_flags: busy %b found %b irq %b want 0", busy, found, irq); end
    checks++; if (found_eng !== '0 || found_nonce !== '0) begin errors++; $display("FAIL reset_found: eng %0d nonce %h want 0", found_eng, found_nonce); end
    checks++; if (batch !== 32'd0) begin errors++; $display("FAIL reset_batch: got %0d want 0", batch); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_launch(input logic [NW-1:0] b);
    base = b; start = 1'b1;
    step();
    start = 1'b0;
    m_rr = 0; m_batch = 0;
    for (int k = 0; k < NE; k++) m_nonce[k] = b + (NW'(k) << SL);
    checks++; if (eng_clear !== 4'hF) begin errors++; $display("FAIL launch_clear: got %b want 1111", eng_clear); end
    checks++; if (busy !== 1'b1 || found !== 1'b0 || irq !== 1'b0 || batch !== 32'd0) begin
      errors++; $display("FAIL launch_status: busy %b found %b irq %b batch %0d want 1 0 0 0", busy, found, irq, batch);
    end
    for (int k = 0; k < NE; k++) begin
      checks++; if (eng_strt !== (NE'(1) << k)) begin errors++; $display("FAIL launch_strb k=%0d: got %b want %b", k, eng_strt, NE'(1) << k); end
      checks++; if (onv(k) !== m_nonce[k]) begin errors++; $display("FAIL launch_nonce k=%0d: got %h want %h", k, onv(k), m_nonce[k]); end
      step();
    end
    checks++; if (eng_strt !== '0 || eng_clear !== '0) begin errors++; $display("FAIL launch_tail: strt %b clear %b want 0", eng_strt, eng_clear); end
  endtask

  task automatic do_misses(input logic [NE-1:0] mask);
    logic [NE-1:0]    exp_q[$];
    logic [NE-1:0]    got_q[$];
    logic [NE*NW-1:0] gotn_q[$];
    int last;
    last = -1;
    for (int i = 0; i < NE; i++) begin
      int idx = (m_rr + i) % NE;
      if (mask[idx]) begin exp_q.push_back(NE'(1) << idx); last = idx; end
    end
    if (last >= 0) m_rr = (last + 1) % NE;
    for (int k = 0; k < NE; k++)
      if (mask[k]) begin m_nonce[k] = m_nonce[k] + (NW'(NE) << SL); m_batch++; end
    eng_rdy = mask; eng_vld = '0;
    step();
    eng_rdy = '0;
    for (int c = 0; c < 8; c++) begin
      if (eng_strt !== '0) begin got_q.push_back(eng_strt); gotn_q.push_back(eng_nonce_o); end
      step();
    end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL miss_count mask=%b: got %0d strobes want %0d", mask, got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL miss_order[%0d]: got %b want %b", i, got_q[i], exp_q[i]); end
      for (int k = 0; k < NE; k++) if (exp_q[i][k]) begin
        checks++; if (gotn_q[i][k*NW +: NW] !== m_nonce[k]) begin errors++; $display("FAIL miss_nonce k=%0d: got %h want %h", k, gotn_q[i][k*NW +: NW], m_nonce[k]); end
      end
    end
    checks++; if (batch !== 32'(m_batch)) begin errors++; $display("FAIL miss_batch: got %0d want %0d", batch, m_batch); end
  endtask

  task automatic test_start_ignored();
    start = 1'b1; base = rand_nonce();
    step();
    start = 1'b0;
    checks++; if (eng_clear !== '0 || eng_strt !== '0 || busy !== 1'b1 || batch !== 32'(m_batch)) begin
      errors++; $display("FAIL start_in_run: clear %b strt %b busy %b batch %0d want 0 0 1 %0d", eng_clear, eng_strt, busy, batch, m_batch);
    end
    for (int k = 0; k < NE; k++) begin
      checks++; if (onv(k) !== m_nonce[k]) begin errors++; $display("FAIL start_in_run_nonce k=%0d: got %h want %h", k, onv(k), m_nonce[k]); end
    end
  endtask

  task automatic test_hit(input logic [NE-1:0] rdy, input logic [NE-1:0] vld, input logic [NW-1:0] win_nonce);
    int w;
    logic [NE-1:0] seen;
    w = 0;
    for (int k = NE - 1; k >= 0; k--) if (rdy[k] && vld[k]) w = k;
    for (int i = 0; i < NE * NW / 32; i++) eng_nonce_i[i*32 +: 32] = $urandom;
    eng_nonce_i[w*NW +: NW] = win_nonce;
    m_batch += $countones(rdy);
    eng_rdy = rdy; eng_vld = vld;
    step();
    eng_rdy = '0; eng_vld = '0;
    checks++; if (found !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL hit_flags: found %b irq %b want 1 1", found, irq); end
    checks++; if (found_eng !== IW'(w) || found_nonce !== win_nonce) begin errors++; $display("FAIL hit_winner: eng %0d nonce %h want %0d %h", found_eng, found_nonce, w, win_nonce); end
    checks++; if (eng_clear !== 4'hF || eng_strt !== '0 || busy !== 1'b0) begin errors++; $display("FAIL hit_clear: clear %b strt %b busy %b want 1111 0 0", eng_clear, eng_strt, busy); end
    checks++; if (batch !== 32'(m_batch)) begin errors++; $display("FAIL hit_batch: got %0d want %0d", batch, m_batch); end
    step();
    checks++; if (eng_clear !== '0 || found !== 1'b1) begin errors++; $display("FAIL hit_hold: clear %b found %b want 0 1", eng_clear, found); end
    eng_rdy = '1; eng_vld = '1;
    step();
    eng_rdy = '0; eng_vld = '0;
    seen = '0;
    repeat (4) begin seen |= eng_strt; step(); end
    checks++; if (seen !== '0 || found_eng !== IW'(w) || batch !== 32'(m_batch)) begin
      errors++; $display("FAIL done_ignore: strobes %b eng %0d batch %0d want 0 %0d %0d", seen, found_eng, batch, w, m_batch);
    end
  endtask

  task automatic test_abort_from_done();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (found !== 1'b0 || irq !== 1'b0 || found_nonce !== '0) begin errors++; $display("FAIL abort_done_flags: found %b irq %b nonce %h want 0", found, irq, found_nonce); end
    checks++; if (eng_clear !== 4'hF || busy !== 1'b0 || batch !== 32'(m_batch)) begin
      errors++; $display("FAIL abort_done_state: clear %b busy %b batch %0d want 1111 0 %0d", eng_clear, busy, batch, m_batch);
    end
    step();
    checks++; if (eng_clear !== '0) begin errors++; $display("FAIL abort_done_pulse: clear %b want 0", eng_clear); end
  endtask

  task automatic test_hit_midlaunch();
    logic [NW-1:0] n3;
    logic [NE-1:0] seen;
    base = rand_nonce(); start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (eng_strt !== 4'b0001) begin errors++; $display("FAIL mid_strb0: got %b want 0001", eng_strt); end
    eng_rdy = 4'b0001; eng_vld = 4'b0001;
    step();
    eng_rdy = '0; eng_vld = '0;
    checks++; if (found !== 1'b0 || batch !== 32'd0) begin errors++; $display("FAIL proto_ignored: found %b batch %0d want 0 0", found, batch); end
    checks++; if (eng_strt !== 4'b0010) begin errors++; $display("FAIL mid_strb1: got %b want 0010", eng_strt); end
    for (int i = 0; i < NE * NW / 32; i++) eng_nonce_i[i*32 +: 32] = $urandom;
    n3 = eng_nonce_i[3*NW +: NW];
    eng_rdy = 4'b1000; eng_vld = 4'b1000;
    step();
    eng_rdy = '0; eng_vld = '0;
    checks++; if (found !== 1'b1 || found_eng !== IW'(3) || found_nonce !== n3) begin errors++; $display("FAIL mid_hit: found %b eng %0d nonce %h want 1 3 %h", found, found_eng, found_nonce, n3); end
    checks++; if (eng_strt !== '0 || eng_clear !== 4'hF || batch !== 32'd1) begin errors++; $display("FAIL mid_hit_state: strt %b clear %b batch %0d want 0 1111 1", eng_strt, eng_clear, batch); end
    seen = '0;
    repeat (5) begin step(); seen |= eng_strt; end
    checks++; if (seen !== '0) begin errors++; $display("FAIL mid_no_launch: strobes %b want 0", seen); end
  endtask

  task automatic test_abort_start();
    logic [NE-1:0] seen;
    base = rand_nonce(); start = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b1; start = 1'b1; base = rand_nonce();
    step();
    abort = 1'b0; start = 1'b0;
    checks++; if (eng_clear !== 4'hF || eng_strt !== '0) begin errors++; $display("FAIL abort_start_pulse: clear %b strt %b want 1111 0", eng_clear, eng_strt); end
    checks++; if (busy !== 1'b0 || found !== 1'b0 || batch !== 32'd0) begin errors++; $display("FAIL abort_start_state: busy %b found %b batch %0d want 0 0 0", busy, found, batch); end
    step();
    checks++; if (eng_clear !== '0) begin errors++; $display("FAIL abort_start_clear: clear %b want 0", eng_clear); end
    seen = '0;
    repeat (4) begin seen |= eng_strt; step(); end
    checks++; if (seen !== '0 || busy !== 1'b0) begin errors++; $display("FAIL abort_start_idle: strobes %b busy %b want 0 0", seen, busy); end
  endtask

  initial begin
    logic [NE-1:0] r, v;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base = '0;
    eng_rdy = '0; eng_vld = '0; eng_nonce_i = '0;
    test_reset(1'b0);

    test_launch(NW'(32'h10));
    checks++; if (onv(2) !== 192'h2_0000_0010) begin errors++; $display("FAIL stagger_nonce2: got %h want 200000010", onv(2)); end
    do_misses(4'b0010);
    checks++; if (onv(1) !== 192'h5_0000_0010) begin errors++; $display("FAIL relaunch_nonce1: got %h want 500000010", onv(1)); end
    do_misses(4'b1001);
    test_start_ignored();
    repeat (6) do_misses(NE'($urandom_range(1, (1 << NE) - 1)));
    test_hit(4'b0110, 4'b0110, NW'(12'hABC));
    test_abort_from_done();

    test_launch({NW{1'b1}} - NW'(32'hFFFF_FFFF));
    do_misses(4'b0001);
    checks++; if (onv(0) !== 192'h3_0000_0000) begin errors++; $display("FAIL wrap_nonce0: got %h want 300000000", onv(0)); end

    repeat (3) begin
      do_misses(NE'($urandom_range(1, (1 << NE) - 1)));
      r = NE'($urandom_range(1, (1 << NE) - 1));
      v = NE'($urandom);
      if ((r & v) == '0) v = v | r;
      test_hit(r, v, rand_nonce());
      test_launch(rand_nonce());
    end

    test_reset(1'b1);
    test_hit_midlaunch();
    test_abort_start();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nonce_dispatcher.md
Name: nonce_dispatcher

Overview:
Schedules a bank of NUM_ENG miner engines that share one message memory and one result path. On each job it hands each engine a disjoint nonce sub-range and launches the engines one per cycle, so memory reads never contend. It re-launches engines that finish without a hit and stops the whole bank on the first valid nonce. It sits between the register/interrupt block and the per-engine hashing datapaths.

Parameters:
NUM_ENG, 4, number of engines driven (2..16)
NONCE_W, 192, nonce width in bits
STRIDE_LOG2, 32, log2 of the nonce sub-range stride per engine slot
IDX_W, $clog2(NUM_ENG), engine index width (derived)

Ports:
Clk  in  1  clock
Rst_n  in  1  reset; synchronous, active-low
Start_I  in  1  one-cycle pulse: start a job with BaseNonce_I
Abort_I  in  1  one-cycle pulse: stop the bank and return to IDLE
BaseNonce_I  in  NONCE_W  job base nonce, sampled with Start_I
EngStrt_O  out  NUM_ENG  one-hot one-cycle launch strobe per engine
EngClear_O  out  NUM_ENG  one-cycle clear to all engines
EngNonce_O  out  NUM_ENG*NONCE_W  per-engine start nonce; engine k at slice [k*NONCE_W +: NONCE_W]
EngRdy_I  in  NUM_ENG  engine k finished its batch (pulse)
EngVld_I  in  NUM_ENG  qualifies EngRdy_I[k]: batch produced a hash below target
EngNonce_I  in  NUM_ENG*NONCE_W  winning nonce reported by engine k, valid with EngRdy_I[k] & EngVld_I[k]
Busy_O  out  1  state is RUN
Found_O  out  1  valid nonce captured (level)
FoundEng_O  out  IDX_W  index of the winning engine
FoundNonce_O  out  NONCE_W  captured winning nonce
Irq_O  out  1  interrupt; level, set together with Found_O
BatchCount_O  out  32  number of completed batches in the current job

Behaviour:
- Reset (Rst_n=0 at a clock edge): state IDLE. All outputs are 0, including the nonce registers, pending mask, round-robin pointer and counters. Reset mid-job drops all in-flight state. No EngClear_O pulse is issued on reset.
- FSM has three states: IDLE, RUN and DONE.
- Start in IDLE or DONE:
  - nonce_k <= BaseNonce_I + (k << STRIDE_LOG2).
  - pending <= all ones; rr_ptr <= 0; BatchCount_O <= 0.
  - Found_O, Irq_O, FoundEng_O and FoundNonce_O are cleared.
  - EngClear_O is all ones for that cycle; next state is RUN.
- Start_I while in RUN is ignored.
- Grant (RUN only):
  - Each cycle, if pending != 0, grant the first set bit searching from rr_ptr upward, with wrap.
  - The grant drives EngStrt_O[g]=1 for exactly one cycle, clears pending[g] and sets rr_ptr <= g+1 mod NUM_ENG.
  - At most one strobe per cycle.
  - Latency: Start_I at cycle 0 gives EngStrt_O[k] at cycle 1+k for the initial launch.
- EngNonce_O[k] holds nonce_k and is stable on every cycle that EngStrt_O[k] is high.
- Miss (RUN, EngRdy_I[k]=1 and EngVld_I[k]=0):
  - nonce_k <= nonce_k + (NUM_ENG << STRIDE_LOG2), modulo 2^NONCE_W (wrap silently).
  - Set pending[k]; BatchCount_O increments.
- Simultaneous misses all set pending in the same cycle, and BatchCount_O adds the popcount of the misses. BatchCount_O saturates at 0xFFFFFFFF.
- Hit (RUN, any EngRdy_I[k] & EngVld_I[k]):
  - The lowest-index hitting engine wins.
  - FoundEng_O <= k; FoundNonce_O <= EngNonce_I[k]; Found_O <= 1; Irq_O <= 1.
  - BatchCount_O increments by the popcount of all EngRdy_I bits that cycle.
  - pending <= 0; no EngStrt_O in that cycle.
  - Next cycle: EngClear_O all ones for one cycle; state DONE.
- In DONE, EngRdy_I and EngVld_I are ignored. Found and Irq hold until Start_I, Abort_I or reset.
- Abort_I (any state): EngClear_O all ones for one cycle (that cycle); state IDLE; pending <= 0. Found_O, Irq_O and FoundNonce_O are cleared. BatchCount_O holds.
- Abort_I has priority over Start_I; both in the same cycle act as Abort.
- EngRdy_I is ignored outside RUN.
- EngRdy_I[k] coinciding with EngStrt_O[k] is treated as a protocol error and ignored.

Test Plan:
- Launch stagger: NUM_ENG=4, STRIDE_LOG2=32, Start with base=0x10 → EngStrt_O = 0001, 0010, 0100, 1000 on cycles 1-4; EngNonce_O[2] = 0x2_0000_0010.
- Miss relaunch: engine 1 EngRdy pulse with Vld=0 → nonce_1 = base+(1<<32)+(4<<32); exactly one EngStrt_O[1] within 4 cycles; BatchCount_O=1.
- Round-robin fairness: misses on engines 0 and 3 in the same cycle with rr_ptr=2 → EngStrt_O[3] first, then [0]; BatchCount_O += 2.
- Hit priority: engines 2 and 1 hit in the same cycle, EngNonce_I[1]=0xABC → FoundEng_O=1, FoundNonce_O=0xABC, Irq_O=1; EngClear_O=1111 next cycle; no further EngStrt_O.
- Wrap: base = 2^192 - (1<<32), engine 0 misses → nonce_0 wraps to (3<<32).
- Abort/reset: Abort_I together with Start_I in RUN → IDLE, EngClear_O=1111 for one cycle, no strobes; Rst_n low mid-RUN → all outputs 0 after the edge.
